btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 103 ++++++++++
 tb/tb_btn_conditioner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Conditions two bouncy pushbuttons and an 8-bit slide-switch bus for a
//   downstream FIFO stage. Each raw input is synchronized, each button is
//   debounced, and an accepted press (0->1) becomes a one-cycle strobe.
//   The switch byte is captured alongside every write strobe.
//
// Parameters
//   DEBOUNCE_CYCLES : stable synchronized cycles needed to accept a change (2..65535)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   CLK           in   sole clock, rising edge
//   RST           in   synchronous reset, active low
//   BTN_WRITE_RAW in   raw write button, 1 = pressed
//   BTN_READ_RAW  in   raw read button, 1 = pressed
//   SW_DATA       in   raw switch byte
//   WR_PULSE      out  one-cycle write strobe
//   RD_PULSE      out  one-cycle read strobe (never coincident with WR_PULSE)
//   DATA_INPUT    out  byte captured with the last write strobe
module btn_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN_WRITE_RAW,
   input  logic       BTN_READ_RAW,
   input  logic [7:0] SW_DATA,
   output logic       WR_PULSE,
   output logic       RD_PULSE,
   output logic [7:0] DATA_INPUT
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Bit 0 = write channel, bit 1 = read channel.
   logic [1:0]       btn_s1, btn_s2;
   logic [7:0]       sw_s1, sw_s2;
   logic [1:0]       deb, deb_d, deb_nxt;
   logic [CNT_W-1:0] cnt     [2];
   logic [CNT_W-1:0] cnt_nxt [2];
   logic             rd_pending;
   logic             wr_press, rd_press, rd_want;

   // Debounce: count consecutive disagreeing cycles; accept on the
   // DEBOUNCE_CYCLES-th one. Any agreeing cycle restarts the count.
   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         deb_nxt[i] = deb[i];
         cnt_nxt[i] = '0;
         if (btn_s2[i] != deb[i]) begin
            if (cnt[i] == CNT_MAX) begin
               deb_nxt[i] = ~deb[i];
            end else begin
               cnt_nxt[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      wr_press = deb[0] & ~deb_d[0];
      rd_press = deb[1] & ~deb_d[1];
      // A read (new or deferred) yields to a write in the same cycle and
      // stays pending until a cycle without a write.
      rd_want  = rd_press | rd_pending;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         btn_s1     <= '0;
         btn_s2     <= '0;
         sw_s1      <= '0;
         sw_s2      <= '0;
         deb        <= '0;
         deb_d      <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            cnt[i] <= '0;
         end
         rd_pending <= 1'b0;
         WR_PULSE   <= 1'b0;
         RD_PULSE   <= 1'b0;
         DATA_INPUT <= '0;
      end else begin
         btn_s1     <= {BTN_READ_RAW, BTN_WRITE_RAW};
         btn_s2     <= btn_s1;
         sw_s1      <= SW_DATA;
         sw_s2      <= sw_s1;
         deb        <= deb_nxt;
         deb_d      <= deb;
         for (int unsigned i = 0; i < 2; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
         rd_pending <= rd_want & wr_press;
         WR_PULSE   <= wr_press;
         RD_PULSE   <= rd_want & ~wr_press;
         if (wr_press) begin
            DATA_INPUT <= sw_s2;
         end
      end
   end

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       BTN_WRITE_RAW = 1'b0;
   logic       BTN_READ_RAW  = 1'b0;
   logic [7:0] SW_DATA = 8'h00;
   logic       WR_PULSE, RD_PULSE;
   logic [7:0] DATA_INPUT;

   int compared   = 0;
   int mismatched = 0;

   btn_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .BTN_WRITE_RAW (BTN_WRITE_RAW),
      .BTN_READ_RAW  (BTN_READ_RAW),
      .SW_DATA       (SW_DATA),
      .WR_PULSE      (WR_PULSE),
      .RD_PULSE      (RD_PULSE),
      .DATA_INPUT    (DATA_INPUT)
   );

   always #5 CLK = ~CLK;

   // Advance past one rising edge; inputs set afterwards are sampled at the next edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      step();
      step();
      compared++;
      if (WR_PULSE !== 1'b0 || RD_PULSE !== 1'b0 || DATA_INPUT !== 8'h00) begin
         mismatched++;
         $display("FAIL reset_state: wr=%b rd=%b data=%h, want wr=0 rd=0 data=00",
                  WR_PULSE, RD_PULSE, DATA_INPUT);
      end
      RST = 1'b1;
      step();
   endtask

   // Buttons released; pulses must stay low and data must hold.
   task automatic test_release(input logic [7:0] exp_data);
      BTN_WRITE_RAW = 1'b0;
      BTN_READ_RAW  = 1'b0;
      for (int k = 0; k < 14; k++) begin
         step();
         compared++;
         if (WR_PULSE !== 1'b0 || RD_PULSE !== 1'b0 || DATA_INPUT !== exp_data) begin
            mismatched++;
            $display("FAIL release k=%0d: wr=%b rd=%b data=%h, want wr=0 rd=0 data=%h",
                     k, WR_PULSE, RD_PULSE, DATA_INPUT, exp_data);
         end
      end
   endtask

   task automatic test_clean_write();
      SW_DATA = 8'hA5;
      BTN_WRITE_RAW = 1'b1;
      for (int k = 0; k < 14; k++) begin
         step();
         compared++;
         if (WR_PULSE !== (k == 6) || RD_PULSE !== 1'b0 ||
             DATA_INPUT !== ((k >= 6) ? 8'hA5 : 8'h00)) begin
            mismatched++;
            $display("FAIL clean_write k=%0d: wr=%b rd=%b data=%h, want wr=%b rd=0 data=%h",
                     k, WR_PULSE, RD_PULSE, DATA_INPUT, (k == 6),
                     ((k >= 6) ? 8'hA5 : 8'h00));
         end
      end
      test_release(8'hA5);
   endtask

   // Exactly DEBOUNCE_CYCLES highs are accepted; one fewer is rejected.
   task automatic test_boundary();
      SW_DATA = 8'h11;
      for (int k = 0; k < 12; k++) begin
         BTN_WRITE_RAW = (k < 4);
         step();
         compared++;
         if (WR_PULSE !== (k == 6) || DATA_INPUT !== ((k >= 6) ? 8'h11 : 8'hA5)) begin
            mismatched++;
            $display("FAIL boundary_4high k=%0d: wr=%b data=%h, want wr=%b data=%h",
                     k, WR_PULSE, DATA_INPUT, (k == 6), ((k >= 6) ? 8'h11 : 8'hA5));
         end
      end
      test_release(8'h11);
      SW_DATA = 8'h22;
      for (int k = 0; k < 12; k++) begin
         BTN_WRITE_RAW = (k < 3);
         step();
         compared++;
         if (WR_PULSE !== 1'b0 || DATA_INPUT !== 8'h11) begin
            mismatched++;
            $display("FAIL boundary_3high k=%0d: wr=%b data=%h, want wr=0 data=11",
                     k, WR_PULSE, DATA_INPUT);
         end
      end
      test_release(8'h11);
   endtask

   // Highs at edges 0-2 and 6-8, lows 3-5 and 9-11, stable from edge 12.
   task automatic test_bounce();
      for (int k = 0; k < 26; k++) begin
         BTN_READ_RAW = (k < 3) || (k >= 6 && k < 9) || (k >= 12);
         step();
         compared++;
         if (RD_PULSE !== (k == 18) || WR_PULSE !== 1'b0 || DATA_INPUT !== 8'h11) begin
            mismatched++;
            $display("FAIL bounce k=%0d: rd=%b wr=%b data=%h, want rd=%b wr=0 data=11",
                     k, RD_PULSE, WR_PULSE, DATA_INPUT, (k == 18));
         end
      end
      test_release(8'h11);
   endtask

   task automatic test_back_to_back();
      SW_DATA = 8'h3C;
      BTN_WRITE_RAW = 1'b1;
      BTN_READ_RAW  = 1'b1;
      for (int k = 0; k < 14; k++) begin
         step();
         compared++;
         if (WR_PULSE !== (k == 6) || RD_PULSE !== (k == 7) ||
             DATA_INPUT !== ((k >= 6) ? 8'h3C : 8'h11)) begin
            mismatched++;
            $display("FAIL simultaneous k=%0d: wr=%b rd=%b data=%h, want wr=%b rd=%b data=%h",
                     k, WR_PULSE, RD_PULSE, DATA_INPUT, (k == 6), (k == 7),
                     ((k >= 6) ? 8'h3C : 8'h11));
         end
         compared++;
         if ((WR_PULSE & RD_PULSE) !== 1'b0) begin
            mismatched++;
            $display("FAIL never_both k=%0d: wr&rd=%b, want 0", k, WR_PULSE & RD_PULSE);
         end
      end
      test_release(8'h3C);
   endtask

   // RST low sampled at edge 3 only; the held button restarts at edge 4.
   task automatic test_reset_mid_count();
      SW_DATA = 8'h5A;
      BTN_WRITE_RAW = 1'b1;
      for (int k = 0; k < 16; k++) begin
         RST = (k != 3);
         step();
         compared++;
         if (WR_PULSE !== (k == 10) || RD_PULSE !== 1'b0 ||
             DATA_INPUT !== ((k < 3) ? 8'h3C : ((k < 10) ? 8'h00 : 8'h5A))) begin
            mismatched++;
            $display("FAIL reset_mid k=%0d: wr=%b rd=%b data=%h, want wr=%b rd=0 data=%h",
                     k, WR_PULSE, RD_PULSE, DATA_INPUT, (k == 10),
                     ((k < 3) ? 8'h3C : ((k < 10) ? 8'h00 : 8'h5A)));
         end
      end
      RST = 1'b1;
      test_release(8'h5A);
   endtask

   task automatic test_data_hold();
      SW_DATA = 8'hFF;
      step();
      step();
      step();
      BTN_READ_RAW = 1'b1;
      for (int k = 0; k < 14; k++) begin
         step();
         compared++;
         if (RD_PULSE !== (k == 6) || WR_PULSE !== 1'b0 || DATA_INPUT !== 8'h5A) begin
            mismatched++;
            $display("FAIL data_hold k=%0d: rd=%b wr=%b data=%h, want rd=%b wr=0 data=5A",
                     k, RD_PULSE, WR_PULSE, DATA_INPUT, (k == 6));
         end
      end
      test_release(8'h5A);
   endtask

   initial begin
      test_reset();
      test_clean_write();
      test_boundary();
      test_bounce();
      test_back_to_back();
      test_reset_mid_count();
      test_data_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
